// File: rtl/i2c_ctrl_pkg.sv
// Shared constants for the I2C write arbiter: FSM state encoding and
// default timing parameters.
package i2c_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Watchdog limit in clk cycles for a single transaction
  localparam int DEFAULT_TIMEOUT_CYCLES = 2000000;

  // Enable-low cycles spent in RELEASE between transactions
  localparam int DEFAULT_RELEASE_CYCLES = 2;

endpackage : i2c_ctrl_pkg

// File: rtl/i2c_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans the request vector starting at
// ptr_i, wrapping past NUM_REQ-1 to 0, and returns the first requester both
// as a one-hot vector and as a binary index. All-zero request gives zero out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Rotating priority search, first hit at or above the pointer wins
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    logic             found;
    int               kk;
    logic [IDX_W-1:0] k;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    kk    = 0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      kk = int'(ptr_i) + i;
      if (kk >= NUM_REQ) kk = kk - NUM_REQ;
      k = IDX_W'(kk);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one I2C write master.
// Flow: IDLE picks a winner, GRANT registers its fields, BUSY holds the
// master enabled until its done flag, RELEASE keeps the enable low for
// RELEASE_CYCLES before the next arbitration.
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a BUSY watchdog that
// aborts a stalled transaction after TIMEOUT_CYCLES and pulses o_err.
module i2c_write_arbiter
  import i2c_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [7*NUM_REQ-1:0] i_dev_addr,
  input  logic [8*NUM_REQ-1:0] i_data_addr,
  input  logic [8*NUM_REQ-1:0] i_wdata,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_done,
  output logic [NUM_REQ-1:0]   o_err,
  output logic                 o_i2c_en,
  output logic [6:0]           o_device_addr,
  output logic [7:0]           o_data_addr,
  output logic [7:0]           o_write_data,
  input  logic                 i_done_flag,
  output logic                 o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int REL_W = $clog2(RELEASE_CYCLES);

  // Reject out-of-range configurations at elaboration
  if (NUM_REQ < 2 || NUM_REQ > 8 || RELEASE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("i2c_write_arbiter: parameter out of range");
  end

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [6:0]         dev_q, dev_d;
  logic [7:0]         daddr_q, daddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [REL_W-1:0]   rel_q, rel_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic [6:0]         sel_dev;
  logic [7:0]         sel_daddr;
  logic [7:0]         sel_wdata;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_oh),
    .idx_o (arb_idx)
  );

  // Pick the latched winner's transaction fields out of the flattened buses
  always_comb begin
    sel_dev   = '0;
    sel_daddr = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx_q == IDX_W'(k)) begin
        sel_dev   = i_dev_addr[7*k +: 7];
        sel_daddr = i_data_addr[8*k +: 8];
        sel_wdata = i_wdata[8*k +: 8];
      end
    end
  end

  // Next-state logic for the FSM, pointer, grant, fields and pulses
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    win_oh_d  = win_oh_q;
    gnt_d     = gnt_q;
    dev_d     = dev_q;
    daddr_d   = daddr_q;
    wdata_d   = wdata_q;
    rel_d     = rel_q;
    done_d    = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          win_idx_d = arb_idx;
          win_oh_d  = arb_oh;
          // Next search starts one above this winner, wrapping to 0
          ptr_d     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        gnt_d   = win_oh_q;
        dev_d   = sel_dev;
        daddr_d = sel_daddr;
        wdata_d = sel_wdata;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_done_flag) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          rel_d   = '0;
          state_d = ST_RELEASE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Master stalled (e.g. missing ACK): abort with an error pulse
          err_d   = gnt_q;
          gnt_d   = '0;
          rel_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        if (rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  // NOTE: reset is asynchronous so the master enable and pulses drop the
  // moment rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      dev_q     <= '0;
      daddr_q   <= '0;
      wdata_q   <= '0;
      rel_q     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the same
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      win_oh_q  <= win_oh_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      dev_q     <= dev_d;
      daddr_q   <= daddr_d;
      wdata_q   <= wdata_d;
      rel_q     <= rel_d;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  assign o_gnt         = gnt_q;
  assign o_done        = done_q;
  assign o_i2c_en      = (state_q == ST_BUSY);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_device_addr = dev_q;
  assign o_data_addr   = daddr_q;
  assign o_write_data  = wdata_q;

`ifdef I2C_ARB_TIMEOUT_EN
  assign o_err = err_q;
`else
  assign o_err = '0;
`endif

endmodule : i2c_write_arbiter
